// File: rtl/cart_pkg.sv
// Shared definitions for the cart download path: loader FSM states, A78
// header geometry and the "ATARI7800" signature bytes.
package cart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    FLUSH,
    DATA,
    DONE
  } loader_state_t;

  // Header length in bytes; also the depth of the header buffer.
  localparam logic [7:0] HDR_LEN = 8'd128;

  // Signature expected at header offsets 1..9, first byte at index 0.
  localparam logic [0:8][7:0] HDR_MAGIC = {
    8'h41, 8'h54, 8'h41, 8'h52, 8'h49, 8'h37, 8'h38, 8'h30, 8'h30
  };

  localparam logic [7:0] HDR_MAGIC_LO = 8'd1;
  localparam logic [7:0] HDR_SIZE_HI  = 8'd49;
  localparam logic [7:0] HDR_TYPE_HI  = 8'd53;
  localparam logic [7:0] HDR_TYPE_LO  = 8'd54;

  function automatic logic [7:0] magic_byte(input logic [3:0] idx);
    return HDR_MAGIC[idx];
  endfunction

endpackage

// File: rtl/spram.sv
// Single-port RAM with registered read (one cycle read latency).
// Ports: clock; address; wren/data write port; q read data, valid the
// cycle after the address is presented.
module spram #(
  parameter int addr_width = 7,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic [addr_width-1:0] address,
  input  logic                  wren,
  input  logic [data_width-1:0] data,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] mem [2**addr_width];

  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/cart_loader.sv
// Byte-stream loader from the HPS download channel into cart ROM.
// The first HDR_LEN bytes are buffered and checked for an A78 header.
// With a valid header the payload is written from ROM address 0 and the
// size/flags fields are decoded; otherwise the buffered bytes are replayed
// to ROM (stalling the source with dl_wait) and the rest is streamed.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   dl_active/wr/data   : download level, byte strobe, byte
//   dl_wait             : stall request to the source (registered)
//   rom_wr/_addr/_data  : ROM byte write port
//   cart_flags/size     : mapper flags and image size, valid with cart_loaded
//   cart_loaded         : image complete
//   overflow            : payload exceeded 2^ROM_AW bytes, excess dropped
module cart_loader import cart_pkg::*; #(
  parameter int ROM_AW = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  output logic              rom_wr,
  output logic [ROM_AW-1:0] rom_wr_addr,
  output logic [7:0]        rom_wr_data,
  output logic [9:0]        cart_flags,
  output logic [31:0]       cart_size,
  output logic              cart_loaded,
  output logic              overflow
);

  localparam int PW = ROM_AW + 1;

  loader_state_t state;
  logic          dl_active_d;
  logic          dl_rise;
  logic [7:0]    cnt;
  logic [7:0]    cnt_nx;
  logic [7:0]    fidx;
  logic [7:0]    flush_len;
  logic          magic_ok;
  logic          hdr_valid;
  logic [31:0]   hsize;
  logic [1:0]    type_hi;
  logic [7:0]    type_lo;
  logic [PW-1:0] pcnt;
  logic [7:0]    moff;
  logic [7:0]    soff;
  logic          hdr_last;
  logic          buf_we;
  logic [6:0]    buf_addr;
  logic [7:0]    buf_q;
  logic          fl_vld_p1;
  logic [6:0]    fl_addr_p1;

  assign dl_rise  = dl_active & ~dl_active_d;
  assign buf_we   = (state == HEADER) && dl_wr;
  assign buf_addr = (state == FLUSH) ? fidx[6:0] : cnt[6:0];
  assign cnt_nx   = cnt + {7'd0, dl_wr};
  assign hdr_last = dl_wr && (cnt == HDR_LEN - 8'd1);
  // Offsets relative to each header field; wrap-around keeps bytes below
  // the field start out of range.
  assign moff     = cnt - HDR_MAGIC_LO;
  assign soff     = cnt - HDR_SIZE_HI;

  spram #(.addr_width(7), .data_width(8)) hdr_buf (
    .clock   (clock),
    .address (buf_addr),
    .wren    (buf_we),
    .data    (dl_data),
    .q       (buf_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      // Track the current level so a download already in progress is not
      // seen as a fresh rise once reset releases.
      dl_active_d <= dl_active;
      cnt         <= 8'd0;
      fidx        <= 8'd0;
      pcnt        <= '0;
      magic_ok    <= 1'b0;
      hdr_valid   <= 1'b0;
      fl_vld_p1   <= 1'b0;
      dl_wait     <= 1'b0;
      rom_wr      <= 1'b0;
      rom_wr_addr <= '0;
      rom_wr_data <= 8'd0;
      cart_flags  <= 10'd0;
      cart_size   <= 32'd0;
      cart_loaded <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dl_active_d <= dl_active;
      rom_wr      <= 1'b0;
      fl_vld_p1   <= 1'b0;
      fl_addr_p1  <= fidx[6:0];

      // p1 -> output: buffer data is valid one cycle after its read
      if (fl_vld_p1) begin
        rom_wr      <= 1'b1;
        rom_wr_addr <= ROM_AW'(fl_addr_p1);
        rom_wr_data <= buf_q;
      end

      if (dl_rise) begin
        cnt         <= 8'd0;
        fidx        <= 8'd0;
        pcnt        <= '0;
        magic_ok    <= 1'b1;
        hdr_valid   <= 1'b0;
        hsize       <= 32'd0;
        type_hi     <= 2'd0;
        type_lo     <= 8'd0;
        cart_loaded <= 1'b0;
        overflow    <= 1'b0;
        cart_size   <= 32'd0;
        cart_flags  <= 10'd0;
        dl_wait     <= 1'b0;
        rom_wr      <= 1'b0;
        state       <= HEADER;
      end else begin
        case (state)
          IDLE: ;

          HEADER: begin
            if (dl_wr) begin
              cnt <= cnt_nx;
              if (moff < 8'd9 && dl_data != magic_byte(moff[3:0])) magic_ok <= 1'b0;
              if (soff < 8'd4) hsize <= {hsize[23:0], dl_data};
              if (cnt == HDR_TYPE_HI) type_hi <= dl_data[1:0];
              if (cnt == HDR_TYPE_LO) type_lo <= dl_data;
            end
            // A byte arriving together with the fall is counted first.
            if (hdr_last && magic_ok) begin
              hdr_valid <= 1'b1;
              pcnt      <= '0;
              state     <= dl_active ? DATA : DONE;
            end else if (hdr_last) begin
              flush_len <= HDR_LEN;
              fidx      <= 8'd0;
              state     <= FLUSH;
            end else if (!dl_active) begin
              flush_len <= cnt_nx;
              fidx      <= 8'd0;
              state     <= (cnt_nx == 8'd0) ? DONE : FLUSH;
            end
          end

          FLUSH: begin
            dl_wait <= 1'b1;
            if (fidx < flush_len) begin
              fl_vld_p1 <= 1'b1;
              fidx      <= fidx + 8'd1;
            end
            // Leave once the final byte is heading to the ROM port; dl_wait
            // stays high through that write.
            if (fl_vld_p1 && {1'b0, fl_addr_p1} == flush_len - 8'd1) begin
              pcnt  <= PW'(flush_len);
              state <= dl_active ? DATA : DONE;
            end
          end

          DATA: begin
            dl_wait <= 1'b0;
            if (dl_wr) begin
              if (pcnt[ROM_AW]) begin
                overflow <= 1'b1;
              end else begin
                rom_wr      <= 1'b1;
                rom_wr_addr <= pcnt[ROM_AW-1:0];
                rom_wr_data <= dl_data;
                pcnt        <= pcnt + PW'(1);
              end
            end
            if (!dl_active) state <= DONE;
          end

          DONE: begin
            dl_wait     <= 1'b0;
            cart_loaded <= 1'b1;
            cart_size   <= (hdr_valid && hsize != 32'd0) ? hsize : 32'(pcnt);
            cart_flags  <= hdr_valid ? {type_hi[0], type_hi[1], type_lo} : 10'd0;
            state       <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
module tb_cart_loader;

  localparam int AW  = 10;
  localparam int ROM = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          dl_active;
  logic          dl_wr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          rom_wr;
  logic [AW-1:0] rom_wr_addr;
  logic [7:0]    rom_wr_data;
  logic [9:0]    cart_flags;
  logic [31:0]   cart_size;
  logic          cart_loaded;
  logic          overflow;

  cart_loader #(.ROM_AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .rom_wr      (rom_wr),
    .rom_wr_addr (rom_wr_addr),
    .rom_wr_data (rom_wr_data),
    .cart_flags  (cart_flags),
    .cart_size   (cart_size),
    .cart_loaded (cart_loaded),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  img[$];
  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  exp_d[$];
  logic [31:0] exp_size;
  logic [9:0]  exp_flags;
  logic        exp_ovf;
  int          wait_seen;

  always @(negedge clock) begin
    if (rom_wr) begin
      wa.push_back(32'(rom_wr_addr));
      wd.push_back(rom_wr_data);
    end
    if (dl_wait) wait_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: an image is headered when it has at least 128 bytes and
  // carries the signature at offsets 1..9; the ROM then receives the bytes
  // after the header, otherwise the whole file, capped at the ROM size.
  function automatic void model();
    logic [7:0] magic[9] = '{8'h41, 8'h54, 8'h41, 8'h52, 8'h49, 8'h37, 8'h38, 8'h30, 8'h30};
    int n = img.size();
    bit hdr = (n >= 128);
    int s;
    int psz;
    logic [31:0] hs;
    if (hdr) for (int k = 0; k < 9; k++) if (img[1+k] != magic[k]) hdr = 0;
    s = hdr ? 128 : 0;
    psz = (n - s > ROM) ? ROM : n - s;
    exp_d.delete();
    for (int i = 0; i < psz; i++) exp_d.push_back(img[s+i]);
    exp_ovf = (n - s) > ROM;
    if (hdr) begin
      hs = {img[49], img[50], img[51], img[52]};
      exp_size  = (hs != 0) ? hs : 32'(psz);
      exp_flags = {img[53][0], img[53][1], img[54]};
    end else begin
      exp_size  = 32'(psz);
      exp_flags = 10'd0;
    end
  endfunction

  task automatic make_image(input bit hdr, input int total, input logic [31:0] size_f,
                            input logic [15:0] type_f);
    logic [7:0] magic[9] = '{8'h41, 8'h54, 8'h41, 8'h52, 8'h49, 8'h37, 8'h38, 8'h30, 8'h30};
    img.delete();
    for (int i = 0; i < total; i++) img.push_back(8'($urandom));
    if (total > 1) img[1] = 8'h00;
    if (hdr) begin
      for (int k = 0; k < 9; k++) img[1+k] = magic[k];
      img[49] = size_f[31:24];
      img[50] = size_f[23:16];
      img[51] = size_f[15:8];
      img[52] = size_f[7:0];
      img[53] = type_f[15:8];
      img[54] = type_f[7:0];
    end
  endtask

  task automatic send_bytes(input int first, input int count, input bit fall_with_last);
    for (int i = first; i < first + count; i++) begin
      int g = 0;
      while (dl_wait && g < 1000) begin
        tick();
        g++;
      end
      if (g >= 1000) chk("dl_wait_bound", 32'(g), 32'd0);
      dl_wr   = 1'b1;
      dl_data = img[i];
      if (fall_with_last && i == first + count - 1) dl_active = 1'b0;
      tick();
      dl_wr = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic run_case(input string tag, input bit fall_with_last);
    int g = 0;
    int nbad = 0;
    int nchk;
    model();
    wa.delete();
    wd.delete();
    wait_seen = 0;
    dl_active = 1'b1;
    tick();
    tick();
    send_bytes(0, img.size(), fall_with_last);
    dl_active = 1'b0;
    while (!cart_loaded && g < 2000) begin
      tick();
      g++;
    end
    chk({tag, "_loaded"}, 32'(cart_loaded), 32'd1);
    chk({tag, "_size"}, cart_size, exp_size);
    chk({tag, "_flags"}, 32'(cart_flags), 32'(exp_flags));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_nwr"}, 32'(wa.size()), 32'(exp_d.size()));
    nchk = (wa.size() < exp_d.size()) ? wa.size() : exp_d.size();
    for (int i = 0; i < nchk; i++)
      if (wa[i] !== 32'(i) || wd[i] !== exp_d[i]) nbad++;
    chk({tag, "_wrbad"}, 32'(nbad), 32'd0);
    repeat (3) tick();
    chk({tag, "_hold"}, 32'(cart_loaded), 32'd1);
    chk({tag, "_wait_end"}, 32'(dl_wait), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_wr"}, 32'(rom_wr), 32'd0);
    chk({tag, "_addr"}, 32'(rom_wr_addr), 32'd0);
    chk({tag, "_data"}, 32'(rom_wr_data), 32'd0);
    chk({tag, "_wait"}, 32'(dl_wait), 32'd0);
    chk({tag, "_flags"}, 32'(cart_flags), 32'd0);
    chk({tag, "_size"}, cart_size, 32'd0);
    chk({tag, "_loaded"}, 32'(cart_loaded), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_data   = 8'd0;
    wait_seen = 0;
    repeat (3) tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick();

    // Headered image, size field set, plain type.
    make_image(1, 128 + 768, 32'h0000_0300, 16'h0002);
    run_case("hdr", 0);
    chk("hdr_no_wait", 32'(wait_seen), 32'd0);
    chk("hdr_flags_const", 32'(cart_flags), 32'h002);

    make_image(1, 128 + 40, 32'h0000_0028, 16'h0200);
    run_case("activision", 0);
    chk("activision_flags", 32'(cart_flags), 32'h100);
    make_image(1, 128 + 40, 32'h0000_0028, 16'h0100);
    run_case("absolute", 0);
    chk("absolute_flags", 32'(cart_flags), 32'h200);

    // Headerless image: buffered bytes replayed under dl_wait.
    make_image(0, 512, 32'd0, 16'd0);
    run_case("headerless", 0);
    chk("headerless_waited", 32'(wait_seen > 0), 32'd1);
    chk("headerless_size", cart_size, 32'd512);

    make_image(0, 50, 32'd0, 16'd0);
    run_case("short50", 0);
    chk("short50_size", cart_size, 32'd50);

    make_image(0, 0, 32'd0, 16'd0);
    run_case("empty", 0);
    chk("empty_nwr", 32'(wa.size()), 32'd0);

    // Payload past the ROM size, size field zero.
    make_image(1, 128 + ROM + 3, 32'd0, 16'h0003);
    run_case("overflow", 0);
    chk("overflow_flag", 32'(overflow), 32'd1);
    chk("overflow_last", (wa.size() > 0) ? wa[wa.size()-1] : 32'hFFFF_FFFF, 32'(ROM - 1));

    // Exactly one header's worth of bytes, last byte arriving with the fall.
    make_image(0, 128, 32'd0, 16'd0);
    run_case("hl128_fall", 1);
    make_image(1, 128, 32'h0000_1234, 16'h0007);
    run_case("hdr128_fall", 1);

    // Reset in the middle of the payload, then a clean reload.
    make_image(1, 128 + 200, 32'd0, 16'h0002);
    dl_active = 1'b1;
    tick();
    tick();
    send_bytes(0, 148, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("midrst");
    wa.delete();
    wd.delete();
    send_bytes(148, 20, 0);
    chk("midrst_ignored_wr", 32'(wa.size()), 32'd0);
    chk("midrst_not_loaded", 32'(cart_loaded), 32'd0);
    dl_active = 1'b0;
    repeat (3) tick();
    make_image(1, 128 + 100, 32'd0, 16'h0002);
    run_case("reload", 0);

    // Randomized images: mixed header/headerless, occasional corrupt magic.
    for (int r = 0; r < 6; r++) begin
      bit hdr = 1'($urandom_range(0, 1));
      int total = hdr ? 128 + int'($urandom_range(0, 600)) : int'($urandom_range(0, 600));
      logic [31:0] sz = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'd0;
      make_image(hdr, total, sz, 16'($urandom));
      if (hdr && $urandom_range(0, 3) == 0) img[$urandom_range(1, 9)] ^= 8'h01;
      run_case($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
